key_menu_ctrl: RTL and testbench
================================

// Module: key_menu_ctrl
// PURPOSE
//   Consumes the debounced key levels and one-cycle press pulses from the key debouncer.
//   Runs a small edit/commit menu over one configuration value (e.g. gate-time select).
//   UP/DOWN keys auto-repeat while held. Feeds the committed value plus a one-cycle
//   update strobe to the measurement/display logic downstream.
// PARAMETERS
//   VAL_W       8     width of edited/committed value
//   VAL_MIN     0     lowest legal value
//   VAL_MAX     99    highest legal value (VAL_MIN <= VAL_INIT <= VAL_MAX < 2**VAL_W)
//   VAL_INIT    10    value loaded at reset
//   STEP        1     increment/decrement amount (1 <= STEP <= VAL_MAX-VAL_MIN)
//   WRAP        1     1: wrap at limits; 0: saturate at limits
//   HOLD_MS     500   ms a held UP/DOWN key waits before the first auto-repeat
//   REPEAT_MS   100   ms between subsequent auto-repeats
//   TIMEOUT_MS  5000  ms of key inactivity in EDIT before the edit is abandoned
// PORTS
//   sys_clk      in   1      system clock (50 MHz)
//   sys_rst      in   1      one clock; reset is synchronous and active-high
//   tick_1ms     in   1      one-cycle strobe every 1 ms
//   sta_key      in   4      debounced key level, one-hot, 1 = held
//   sta_key_pos  in   4      one-cycle press pulse per key
//                            [0]=MODE [1]=UP [2]=DOWN [3]=ENTER
//   edit_active  out  1      1 while in EDIT
//   edit_val     out  VAL_W  value being edited (shadow)
//   cfg_val      out  VAL_W  committed value
//   cfg_valid    out  1      one-cycle strobe: cfg_val just updated
//   edit_tmo     out  1      one-cycle strobe: edit abandoned on timeout
// BEHAVIOUR
//   Reset
//   - state=IDLE; cfg_val=edit_val=VAL_INIT.
//   - edit_active, cfg_valid, edit_tmo, hold_cnt, tmo_cnt all 0.
//   - Reset overrides everything, mid-edit included; edit is discarded with no strobes.
//   FSM states: IDLE, EDIT, COMMIT. Registered outputs; 1-cycle latency from pulse to effect.
//   IDLE
//   - MODE pulse -> EDIT, edit_val<=cfg_val.
//   - All other keys are ignored.
//   EDIT (edit_active=1). Pulse priority ENTER > MODE > UP > DOWN.
//   - ENTER -> COMMIT, cfg_val<=edit_val.
//   - MODE -> IDLE (cancel); cfg_val unchanged, no cfg_valid.
//   - UP: edit_val+STEP. If the sum > VAL_MAX: WRAP ? VAL_MIN : VAL_MAX.
//   - DOWN: edit_val-STEP. If edit_val < VAL_MIN+STEP: WRAP ? VAL_MAX : VAL_MIN.
//   - Arithmetic is done in VAL_W+1 bits, so there is no silent overflow.
//   COMMIT
//   - cfg_valid=1 for exactly this cycle, then -> IDLE unconditionally.
//   - Pulses arriving during COMMIT are dropped.
//   Auto-repeat (EDIT only)
//   - hold_cnt counts tick_1ms while sta_key[1] or sta_key[2] is high.
//   - hold_cnt clears on any sta_key_pos, on release, or on leaving EDIT.
//   - At hold_cnt==HOLD_MS: one step in the held direction; hold_cnt reloads to HOLD_MS-REPEAT_MS.
//   - Further steps every REPEAT_MS ms while held.
//   Timeout (EDIT only)
//   - tmo_cnt counts tick_1ms and clears on any sta_key!=0 or sta_key_pos!=0.
//   - At tmo_cnt==TIMEOUT_MS: -> IDLE, edit_tmo pulses 1 cycle, cfg_val unchanged.
//   - A key pulse in the same cycle as timeout wins; timeout is not taken.
//   Counters
//   - Width is $clog2(max(HOLD_MS,TIMEOUT_MS)+1). Counters never wrap; they hold at terminal.
//   - A pulse and a repeat step in the same cycle apply only the pulse (hold_cnt clears).
// TESTING (VAL_MIN=0 VAL_MAX=9 VAL_INIT=5 STEP=1 HOLD_MS=4 REPEAT_MS=2 TIMEOUT_MS=10)
//   1 Reset, then MODE, UP x3, ENTER -> edit_val 5,6,7,8.
//     Then cfg_val=8 with cfg_valid high 1 cycle; back to IDLE.
//   2 WRAP=1: edit at 9, UP -> 0; DOWN -> 9.
//     WRAP=0: edit at 9, UP -> 9; at 0, DOWN -> 0.
//   3 Hold UP from edit_val=2 for 10 ticks -> 3 at pos, then +1 at ticks 4,6,8,10; final 7.
//   4 MODE, UP, then MODE again -> IDLE, cfg_val stays 5, no cfg_valid.
//   5 Enter EDIT, no keys for 10 ticks -> edit_tmo 1 cycle, IDLE, cfg_val 5.
//     Key at tick 9 restarts the count.
//   6 Assert sys_rst mid-hold in EDIT -> next cycle IDLE, cfg_val=5, all strobes 0.
//     Also: ENTER+UP pulses in the same cycle -> commit only, no step.

Source files
------------

// File: rtl/key_menu_ctrl.sv
// Edit/commit menu over one configuration value, driven by debounced key levels and press pulses.
// UP/DOWN auto-repeat while held; an idle EDIT session is abandoned after a timeout.
module key_menu_ctrl #(
  parameter int VAL_W      = 8,
  parameter int VAL_MIN    = 0,
  parameter int VAL_MAX    = 99,
  parameter int VAL_INIT   = 10,
  parameter int STEP       = 1,
  parameter int WRAP       = 1,
  parameter int HOLD_MS    = 500,
  parameter int REPEAT_MS  = 100,
  parameter int TIMEOUT_MS = 5000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             tick_1ms,
  input  logic [3:0]       sta_key,
  input  logic [3:0]       sta_key_pos,
  output logic             edit_active,
  output logic [VAL_W-1:0] edit_val,
  output logic [VAL_W-1:0] cfg_val,
  output logic             cfg_valid,
  output logic             edit_tmo
);

  localparam int CNT_MAX = (HOLD_MS > TIMEOUT_MS) ? HOLD_MS : TIMEOUT_MS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int XW      = VAL_W + 1;

  localparam logic [VAL_W-1:0] UP_LIM = (WRAP != 0) ? VAL_W'(VAL_MIN) : VAL_W'(VAL_MAX);
  localparam logic [VAL_W-1:0] DN_LIM = (WRAP != 0) ? VAL_W'(VAL_MAX) : VAL_W'(VAL_MIN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EDIT,
    S_COMMIT
  } state_e;

  state_e           state_q, state_d;
  logic [VAL_W-1:0] edit_val_q, edit_val_d;
  logic [VAL_W-1:0] cfg_val_q, cfg_val_d;
  logic             edit_tmo_q, edit_tmo_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic [VAL_W:0]   ev_x, up_sum, dn_diff;
  logic [VAL_W-1:0] up_val, dn_val;
  logic [CNT_W-1:0] hold_inc, tmo_inc;

  // Extra bit keeps the limit checks free of overflow
  assign ev_x    = {1'b0, edit_val_q};
  assign up_sum  = ev_x + XW'(STEP);
  assign dn_diff = ev_x - XW'(STEP);
  assign up_val  = (up_sum > XW'(VAL_MAX)) ? UP_LIM : up_sum[VAL_W-1:0];
  assign dn_val  = (ev_x < XW'(VAL_MIN + STEP)) ? DN_LIM : dn_diff[VAL_W-1:0];

  assign hold_inc = (hold_cnt_q == CNT_W'(CNT_MAX)) ? hold_cnt_q : hold_cnt_q + 1'b1;
  assign tmo_inc  = (tmo_cnt_q == CNT_W'(CNT_MAX)) ? tmo_cnt_q : tmo_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    edit_val_d = edit_val_q;
    cfg_val_d  = cfg_val_q;
    edit_tmo_d = 1'b0;
    hold_cnt_d = '0;
    tmo_cnt_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (sta_key_pos[0]) begin
          state_d    = S_EDIT;
          edit_val_d = cfg_val_q;
        end
      end
      S_EDIT: begin
        if (sta_key_pos != 4'b0000) begin
          if (sta_key_pos[3]) begin
            state_d   = S_COMMIT;
            cfg_val_d = edit_val_q;
          end else if (sta_key_pos[0]) begin
            state_d = S_IDLE;
          end else if (sta_key_pos[1]) begin
            edit_val_d = up_val;
          end else if (sta_key_pos[2]) begin
            edit_val_d = dn_val;
          end
        end else begin
          // The tick that brings the hold count to HOLD_MS steps; reloading keeps REPEAT_MS spacing
          if (sta_key[1] || sta_key[2]) begin
            hold_cnt_d = hold_cnt_q;
            if (tick_1ms) begin
              if (hold_inc >= CNT_W'(HOLD_MS)) begin
                edit_val_d = sta_key[1] ? up_val : dn_val;
                hold_cnt_d = CNT_W'(HOLD_MS - REPEAT_MS);
              end else begin
                hold_cnt_d = hold_inc;
              end
            end
          end
          if (sta_key == 4'b0000) begin
            tmo_cnt_d = tmo_cnt_q;
            if (tick_1ms) begin
              if (tmo_inc >= CNT_W'(TIMEOUT_MS)) begin
                state_d    = S_IDLE;
                edit_tmo_d = 1'b1;
                tmo_cnt_d  = '0;
              end else begin
                tmo_cnt_d = tmo_inc;
              end
            end
          end
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      edit_val_q <= VAL_W'(VAL_INIT);
      cfg_val_q  <= VAL_W'(VAL_INIT);
      edit_tmo_q <= 1'b0;
      hold_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      edit_val_q <= edit_val_d;
      cfg_val_q  <= cfg_val_d;
      edit_tmo_q <= edit_tmo_d;
      hold_cnt_q <= hold_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign edit_active = (state_q == S_EDIT);
  assign cfg_valid   = (state_q == S_COMMIT);
  assign edit_val    = edit_val_q;
  assign cfg_val     = cfg_val_q;
  assign edit_tmo    = edit_tmo_q;

endmodule

// File: tb/tb_key_menu_ctrl.sv
// Bench for key_menu_ctrl: wrapping and saturating instances share one stimulus stream
// and are checked every cycle against a tick-counting behavioural model.
module tb_key_menu_ctrl;

  localparam int VW = 8, VMIN = 0, VMAX = 9, VINIT = 5, STEP = 1;
  localparam int HOLD = 4, REP = 2, TMO = 10;
  localparam logic [3:0] K_MODE = 4'b0001, K_UP = 4'b0010, K_DN = 4'b0100, K_ENT = 4'b1000;
  localparam logic [3:0] K_NONE = 4'b0000;

  logic          clk = 1'b0;
  logic          rst, tick;
  logic [3:0]    key, pos;
  logic          w_active, w_vld, w_tmo, s_active, s_vld, s_tmo;
  logic [VW-1:0] w_ev, w_cfg, s_ev, s_cfg;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: values per instance (0 = wrap, 1 = saturate); session flags and tick counts shared
  int m_ev[2], m_cfg[2];
  bit m_edit, m_commit, m_tmo;
  int m_held, m_idle;

  always #10 clk = ~clk;

  key_menu_ctrl #(.VAL_W(VW), .VAL_MIN(VMIN), .VAL_MAX(VMAX), .VAL_INIT(VINIT), .STEP(STEP),
                  .WRAP(1), .HOLD_MS(HOLD), .REPEAT_MS(REP), .TIMEOUT_MS(TMO)) u_wrap (
    .sys_clk(clk), .sys_rst(rst), .tick_1ms(tick), .sta_key(key), .sta_key_pos(pos),
    .edit_active(w_active), .edit_val(w_ev), .cfg_val(w_cfg), .cfg_valid(w_vld), .edit_tmo(w_tmo));

  key_menu_ctrl #(.VAL_W(VW), .VAL_MIN(VMIN), .VAL_MAX(VMAX), .VAL_INIT(VINIT), .STEP(STEP),
                  .WRAP(0), .HOLD_MS(HOLD), .REPEAT_MS(REP), .TIMEOUT_MS(TMO)) u_sat (
    .sys_clk(clk), .sys_rst(rst), .tick_1ms(tick), .sta_key(key), .sta_key_pos(pos),
    .edit_active(s_active), .edit_val(s_ev), .cfg_val(s_cfg), .cfg_valid(s_vld), .edit_tmo(s_tmo));

  function automatic int f_up(input int v, input int wrap);
    if (v + STEP > VMAX) return (wrap != 0) ? VMIN : VMAX;
    return v + STEP;
  endfunction

  function automatic int f_dn(input int v, input int wrap);
    if (v - STEP < VMIN) return (wrap != 0) ? VMAX : VMIN;
    return v - STEP;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] k, input logic [3:0] p, input logic t, input logic r);
    bit was_edit, was_commit;
    if (r) begin
      m_edit = 0; m_commit = 0; m_tmo = 0; m_held = 0; m_idle = 0;
      for (int j = 0; j < 2; j++) begin m_ev[j] = VINIT; m_cfg[j] = VINIT; end
      return;
    end
    was_edit = m_edit; was_commit = m_commit;
    m_commit = 0; m_tmo = 0;
    if (was_commit) begin
      // pulses during commit are dropped
    end else if (!was_edit) begin
      if (p[0]) begin
        m_edit = 1;
        for (int j = 0; j < 2; j++) m_ev[j] = m_cfg[j];
      end
    end else if (p != 4'b0000) begin
      m_held = 0; m_idle = 0;
      if (p[3]) begin
        m_edit = 0; m_commit = 1;
        for (int j = 0; j < 2; j++) m_cfg[j] = m_ev[j];
      end else if (p[0]) m_edit = 0;
      else if (p[1]) for (int j = 0; j < 2; j++) m_ev[j] = f_up(m_ev[j], 1 - j);
      else if (p[2]) for (int j = 0; j < 2; j++) m_ev[j] = f_dn(m_ev[j], 1 - j);
    end else begin
      if (k[1] || k[2]) begin
        if (t) begin
          m_held++;
          if (m_held >= HOLD && ((m_held - HOLD) % REP) == 0)
            for (int j = 0; j < 2; j++) m_ev[j] = k[1] ? f_up(m_ev[j], 1 - j) : f_dn(m_ev[j], 1 - j);
        end
      end else m_held = 0;
      if (k != 4'b0000) m_idle = 0;
      else if (t) begin
        m_idle++;
        if (m_idle == TMO) begin m_edit = 0; m_tmo = 1; end
      end
    end
    if (!m_edit) begin m_held = 0; m_idle = 0; end
  endtask

  task automatic compare_all();
    chk("w_active", w_active, m_edit);  chk("s_active", s_active, m_edit);
    chk("w_cfg_vld", w_vld, m_commit);  chk("s_cfg_vld", s_vld, m_commit);
    chk("w_tmo", w_tmo, m_tmo);         chk("s_tmo", s_tmo, m_tmo);
    chk("w_edit_val", w_ev, m_ev[0]);   chk("s_edit_val", s_ev, m_ev[1]);
    chk("w_cfg_val", w_cfg, m_cfg[0]);  chk("s_cfg_val", s_cfg, m_cfg[1]);
  endtask

  task automatic cycle(input logic [3:0] k, input logic [3:0] p, input logic t, input logic r);
    rst = r; key = k; pos = p; tick = t;
    @(posedge clk);
    model_step(k, p, t, r);
    #1;
    compare_all();
  endtask

  task automatic press(input logic [3:0] k);
    cycle(k, k, 1'b0, 1'b0);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) cycle(K_NONE, K_NONE, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; key = K_NONE; pos = K_NONE; tick = 1'b0;
    cycle(K_NONE, K_NONE, 1'b0, 1'b1);
    cycle(K_NONE, K_NONE, 1'b0, 1'b1);
    chk("rst_active", w_active, 0); chk("rst_edit_val", w_ev, 5); chk("rst_cfg_val", w_cfg, 5);
    chk("rst_cfg_vld", w_vld, 0);   chk("rst_tmo", w_tmo, 0);

    // Basic edit and commit
    press(K_MODE);
    chk("t1_enter_edit", w_active, 1); chk("t1_ev0", w_ev, 5);
    for (int i = 0; i < 3; i++) begin
      press(K_UP);
      chk("t1_up", w_ev, 6 + i);
    end
    press(K_ENT);
    chk("t1_commit_vld", w_vld, 1); chk("t1_commit_val", w_cfg, 8);
    cycle(K_NONE, K_NONE, 1'b0, 1'b0);
    chk("t1_vld_drop", w_vld, 0); chk("t1_back_idle", w_active, 0);

    // Limits: wrap vs saturate
    press(K_MODE); press(K_UP);
    chk("t2_at_max", w_ev, 9);
    press(K_UP);
    chk("t2_wrap_up", w_ev, 0); chk("t2_sat_up", s_ev, 9);
    press(K_DN);
    chk("t2_wrap_dn", w_ev, 9); chk("t2_sat_dn", s_ev, 8);
    for (int i = 0; i < 10; i++) press(K_DN);
    chk("t2_wrap_dn_min", w_ev, 9); chk("t2_sat_dn_min", s_ev, 0);
    press(K_MODE);
    chk("t2_cancel", w_active, 0); chk("t2_cfg_kept", s_cfg, 8);

    // Auto-repeat from 2
    press(K_MODE);
    for (int i = 0; i < 6; i++) press(K_DN);
    chk("t3_start", w_ev, 2);
    press(K_UP);
    chk("t3_pos_step", w_ev, 3);
    for (int i = 1; i <= 10; i++) begin
      cycle(K_UP, K_NONE, 1'b1, 1'b0);
      if (i == 3) chk("t3_tick3", w_ev, 3);
      if (i == 4) chk("t3_tick4", w_ev, 4);
      cycle(K_UP, K_NONE, 1'b0, 1'b0);
    end
    chk("t3_final", w_ev, 7); chk("t3_final_sat", s_ev, 7);
    cycle(K_NONE, K_NONE, 1'b0, 1'b0);

    // Cancel leaves committed value alone
    press(K_MODE);
    press(K_MODE); press(K_UP);
    chk("t4_edit_up", w_ev, 9);
    press(K_MODE);
    chk("t4_cancel_idle", w_active, 0); chk("t4_cfg_kept", w_cfg, 8); chk("t4_no_vld", w_vld, 0);

    // Timeout
    press(K_MODE);
    idle_ticks(9);
    chk("t5_pre_tmo", w_active, 1);
    idle_ticks(1);
    chk("t5_tmo", w_tmo, 1); chk("t5_tmo_idle", w_active, 0); chk("t5_tmo_cfg", w_cfg, 8);
    cycle(K_NONE, K_NONE, 1'b0, 1'b0);
    chk("t5_tmo_drop", w_tmo, 0);
    press(K_MODE);
    idle_ticks(8);
    cycle(K_UP, K_NONE, 1'b1, 1'b0);
    idle_ticks(9);
    chk("t5_restart_active", w_active, 1); chk("t5_restart_no_tmo", w_tmo, 0);
    idle_ticks(1);
    chk("t5_restart_tmo", w_tmo, 1);
    press(K_MODE);
    idle_ticks(9);
    cycle(K_UP, K_UP, 1'b1, 1'b0);
    chk("t5_pulse_wins", w_tmo, 0); chk("t5_pulse_active", w_active, 1); chk("t5_pulse_step", w_ev, 9);
    press(K_MODE);

    // Reset mid-hold, then simultaneous ENTER+UP
    press(K_MODE); press(K_UP);
    for (int i = 0; i < 3; i++) cycle(K_UP, K_NONE, 1'b1, 1'b0);
    cycle(K_UP, K_NONE, 1'b1, 1'b1);
    chk("t6_rst_idle", w_active, 0); chk("t6_rst_cfg", w_cfg, 5); chk("t6_rst_ev", w_ev, 5);
    chk("t6_rst_vld", w_vld, 0);     chk("t6_rst_tmo", w_tmo, 0);
    cycle(K_NONE, K_NONE, 1'b0, 1'b0);
    press(K_MODE); press(K_UP);
    cycle(K_ENT | K_UP, K_ENT | K_UP, 1'b0, 1'b0);
    chk("t6_ent_up_vld", w_vld, 1); chk("t6_ent_up_cfg", w_cfg, 6); chk("t6_ent_up_ev", w_ev, 6);
    cycle(K_NONE, K_NONE, 1'b0, 1'b0);
    cycle(K_NONE, K_NONE, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
